seq_right_shifter: RTL and testbench

Multi-cycle 32-bit right shifter supporting logical (SRL) and arithmetic (SRA) shifts. It complements the existing combinational left-shift stages and is used by the ALU/execute path for right shifts where a registered, handshake-driven result is preferred over a full combinational barrel. Shift stages of 16, 8, 4, 2 and 1 are applied one per clock. The latency is fixed regardless of shift amount, and completion is signalled with a one-cycle ready pulse.

---
 rtl/seq_right_shifter.sv | 78 +++++++
 tb/tb_seq_right_shifter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_right_shifter.sv
// Multi-cycle 32-bit right shifter (SRL/SRA): one shift stage (16,8,4,2,1) per clock,
// fixed five-cycle latency, one-cycle data_resultRDY pulse on completion.
module seq_right_shifter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic [31:0] data_operandA,
  input  logic [4:0]  ctrl_shiftamt,
  input  logic        ctrl_arith,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [2:0]  k;
  logic [31:0] work;
  logic [4:0]  amt;
  logic        fill;
  logic [31:0] next_work;

  // Stage k shifts by 2^k only when the matching amount bit is set.
  always_comb begin
    next_work = work;
    case (k)
      3'd4: if (amt[4]) next_work = {{16{fill}}, work[31:16]};
      3'd3: if (amt[3]) next_work = {{8{fill}}, work[31:8]};
      3'd2: if (amt[2]) next_work = {{4{fill}}, work[31:4]};
      3'd1: if (amt[1]) next_work = {{2{fill}}, work[31:2]};
      3'd0: if (amt[0]) next_work = {fill, work[31:1]};
      default: next_work = work;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      k              <= '0;
      work           <= '0;
      amt            <= '0;
      fill           <= 1'b0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          data_resultRDY <= 1'b0;
          if (ctrl_shift) begin
            work  <= data_operandA;
            amt   <= ctrl_shiftamt;
            fill  <= ctrl_arith & data_operandA[31];
            k     <= 3'd4;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work <= next_work;
          if (k == 3'd0) begin
            state          <= DONE;
            data_result    <= next_work;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
          end else begin
            k <= k - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter: latency, fill modes, ignored starts,
// mid-operation reset, back-to-back starts and an operator-checked random sweep.
module tb_seq_right_shifter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_shift;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic        ctrl_arith;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] last_result = '0;

  seq_right_shifter dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_shift    (ctrl_shift),
    .data_operandA (data_operandA),
    .ctrl_shiftamt (ctrl_shiftamt),
    .ctrl_arith    (ctrl_arith),
    .data_result   (data_result),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start at the next edge, scramble inputs afterwards, then expect RDY exactly 5 edges later.
  task automatic run_op(input logic [31:0] op, input logic [4:0] amt, input logic a,
                        input logic [31:0] exp, input string tag);
    int cyc;
    @(negedge clock);
    data_operandA = op; ctrl_shiftamt = amt; ctrl_arith = a; ctrl_shift = 1'b1;
    @(negedge clock);
    ctrl_shift = 1'b0; data_operandA = ~op; ctrl_shiftamt = ~amt; ctrl_arith = ~a;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_hold"}, data_result, last_result);
    cyc = 0;
    while (data_resultRDY !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd5);
    check({tag, "_res"}, data_result, exp);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    last_result = exp;
    @(negedge clock);
    check({tag, "_rdy_drop"}, 32'(data_resultRDY), 32'd0);
  endtask

  initial begin
    int cyc;
    int rdy_cnt;
    int busy_cnt;
    logic [31:0] r_op;
    logic [4:0]  r_amt;
    logic        r_a;
    logic [31:0] r_exp;

    reset = 1'b1; ctrl_shift = 1'b0; data_operandA = '0; ctrl_shiftamt = '0; ctrl_arith = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_result", data_result, 32'h0);
    check("rst_rdy", 32'(data_resultRDY), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_op(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, "srl31");
    run_op(32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, "sra_neg");
    run_op(32'h7FFF_FFF0, 5'd4,  1'b1, 32'h07FF_FFFF, "sra_pos");
    run_op(32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, "zero_srl");
    run_op(32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, "zero_sra");
    run_op(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, "sra31");

    // Starts presented mid-shift must be dropped.
    @(negedge clock);
    data_operandA = 32'hFFFF_0000; ctrl_shiftamt = 5'd8; ctrl_arith = 1'b0; ctrl_shift = 1'b1;
    @(negedge clock);
    ctrl_shift = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    @(negedge clock);
    ctrl_shift = 1'b1; data_operandA = 32'h1234_5678; ctrl_shiftamt = 5'd1; ctrl_arith = 1'b1;
    @(negedge clock);
    data_operandA = 32'hDEAD_BEEF;
    @(negedge clock);
    ctrl_shift = 1'b0;
    cyc = 3;
    while (data_resultRDY !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("ign_lat", 32'(cyc), 32'd5);
    check("ign_res", data_result, 32'h00FF_FF00);
    last_result = 32'h00FF_FF00;
    rdy_cnt = 0; busy_cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    check("ign_extra_rdy", 32'(rdy_cnt), 32'd0);
    check("ign_extra_busy", 32'(busy_cnt), 32'd0);
    check("ign_res_hold", data_result, 32'h00FF_FF00);

    // Reset sampled at edge N+3 of an SRA.
    @(negedge clock);
    data_operandA = 32'h8000_0000; ctrl_shiftamt = 5'd4; ctrl_arith = 1'b1; ctrl_shift = 1'b1;
    @(negedge clock);
    ctrl_shift = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_rdy", 32'(data_resultRDY), 32'd0);
    check("mrst_result", data_result, 32'h0);
    rdy_cnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_cnt++;
    end
    check("mrst_no_rdy", 32'(rdy_cnt), 32'd0);
    last_result = 32'h0;
    run_op(32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000, "post_rst");

    // Second start presented during the DONE cycle.
    @(negedge clock);
    data_operandA = 32'hA5A5_A5A5; ctrl_shiftamt = 5'd1; ctrl_arith = 1'b0; ctrl_shift = 1'b1;
    @(negedge clock);
    ctrl_shift = 1'b0;
    cyc = 0;
    while (data_resultRDY !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("b2b_lat1", 32'(cyc), 32'd5);
    check("b2b_res1", data_result, 32'h52D2_D2D2);
    data_operandA = 32'hA5A5_A5A5; ctrl_shiftamt = 5'd1; ctrl_arith = 1'b1; ctrl_shift = 1'b1;
    @(negedge clock);
    cyc++;
    ctrl_shift = 1'b0;
    check("b2b_rdy_drop", 32'(data_resultRDY), 32'd0);
    check("b2b_busy2", 32'(busy), 32'd1);
    check("b2b_hold", data_result, 32'h52D2_D2D2);
    while (data_resultRDY !== 1'b1 && cyc < 30) begin
      @(negedge clock);
      cyc++;
    end
    check("b2b_lat2", 32'(cyc), 32'd11);
    check("b2b_res2", data_result, 32'hD2D2_D2D2);
    last_result = 32'hD2D2_D2D2;
    @(negedge clock);
    check("b2b_rdy_end", 32'(data_resultRDY), 32'd0);

    for (int i = 0; i < 24; i++) begin
      r_op  = $urandom;
      r_amt = 5'($urandom_range(0, 31));
      r_a   = 1'($urandom_range(0, 1));
      if (i == 0) r_op[31] = 1'b1;
      if (r_a) r_exp = $signed(r_op) >>> r_amt;
      else     r_exp = r_op >> r_amt;
      run_op(r_op, r_amt, r_a, r_exp, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
